// File: rtl/video_stream_decoder.sv
// video_stream_decoder
// Receives the line-buffer video stream and recovers pixel coordinates,
// per-line width and sideband fields, and per-frame geometry. It also flags
// protocol violations for each frame.
//
// Ports
//   clk_vid       video clock; all logic runs on the rising edge
//   reset         synchronous, active-high
//   vsync_in      1-cycle frame-start pulse
//   hsync_in      1-cycle line-start pulse
//   de_in         pixel valid, contiguous per line
//   rgb_in        pixel data while de_in=1; sideband word on the first cycle
//                 with de_in=0 after a burst
//   pix_valid     registered copy of accepted de_in
//   pix_x/pix_y   0-based column/row of pix_rgb
//   pix_rgb       pixel data
//   line_done     1-cycle pulse after a line's sideband is decoded
//   line_width    de count of the last completed line
//   slot          sideband [16:14] of the last line
//   line_224      sideband [13] of the last line
//   frame_done    1-cycle pulse on a vsync that closes a non-empty frame
//   frame_width   width of the closed frame's first line
//   frame_height  number of lines in the closed frame
//   err_width     closed frame had a line whose width differed from the first
//   err_sync      closed frame had a sync/de violation
//   err_sideband  closed frame had a malformed sideband word
//
// State | meaning
//   IDLE      | after reset; everything is ignored until vsync
//   LINE_WAIT | inside a frame, de low
//   ACTIVE    | de burst in progress
//   TRAIL     | cycle after the sideband word; a burst starting here is an error
module video_stream_decoder (
  input  logic        clk_vid,
  input  logic        reset,
  input  logic        vsync_in,
  input  logic        hsync_in,
  input  logic        de_in,
  input  logic [23:0] rgb_in,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [23:0] pix_rgb,
  output logic        line_done,
  output logic [9:0]  line_width,
  output logic [2:0]  slot,
  output logic        line_224,
  output logic        frame_done,
  output logic [9:0]  frame_width,
  output logic [9:0]  frame_height,
  output logic        err_width,
  output logic        err_sync,
  output logic        err_sideband
);

  typedef enum logic [1:0] {IDLE, LINE_WAIT, ACTIVE, TRAIL} state_t;

  localparam logic [9:0] CNT_MAX = 10'h3FF;

  state_t     state, state_next;
  logic [9:0] x_cnt, y_cnt, first_width;
  logic       loc_err_width, loc_err_sync, loc_err_sb;
  logic       burst_since_hs;

  logic       line_end, burst_start, pix_take, frame_close, proto_err;
  logic [9:0] y_after, fw_after, x_next;
  logic       ew_after, es_after, esb_after;

  // The first de=0 cycle of ACTIVE carries the sideband word, so the line is
  // closed there and line_* outputs appear one cycle later while in TRAIL.
  // A vsync on that cycle still counts the line before closing the frame.
  always_comb begin
    state_next  = state;
    line_end    = 1'b0;
    burst_start = 1'b0;
    pix_take    = 1'b0;
    frame_close = 1'b0;
    proto_err   = 1'b0;
    case (state)
      IDLE: begin
        if (vsync_in) state_next = LINE_WAIT;
      end
      LINE_WAIT: begin
        if (vsync_in) begin
          frame_close = 1'b1;
        end else if (de_in) begin
          burst_start = 1'b1;
          pix_take    = 1'b1;
          state_next  = ACTIVE;
        end
      end
      ACTIVE: begin
        if (de_in) begin
          if (vsync_in) begin
            frame_close = 1'b1;
            state_next  = LINE_WAIT;
          end else begin
            pix_take = 1'b1;
          end
        end else begin
          line_end = 1'b1;
          if (vsync_in) begin
            frame_close = 1'b1;
            state_next  = LINE_WAIT;
          end else begin
            state_next = TRAIL;
          end
        end
      end
      TRAIL: begin
        if (vsync_in) begin
          frame_close = 1'b1;
          state_next  = LINE_WAIT;
        end else if (de_in) begin
          burst_start = 1'b1;
          pix_take    = 1'b1;
          proto_err   = 1'b1;
          state_next  = ACTIVE;
        end else begin
          state_next = LINE_WAIT;
        end
      end
      default: state_next = IDLE;
    endcase

    if (burst_start && burst_since_hs && !hsync_in) proto_err = 1'b1;
    if (hsync_in && de_in && state != IDLE && !vsync_in) proto_err = 1'b1;
    if (pix_take && !burst_start && x_cnt == CNT_MAX) proto_err = 1'b1;
    if (line_end && y_cnt == CNT_MAX) proto_err = 1'b1;

    x_next    = burst_start ? 10'd1 : ((x_cnt == CNT_MAX) ? CNT_MAX : x_cnt + 10'd1);
    y_after   = (line_end && y_cnt != CNT_MAX) ? y_cnt + 10'd1 : y_cnt;
    fw_after  = (line_end && y_cnt == 10'd0) ? x_cnt : first_width;
    ew_after  = loc_err_width | (line_end && y_cnt != 10'd0 && x_cnt != first_width);
    es_after  = loc_err_sync | proto_err;
    esb_after = loc_err_sb | (line_end && ((|rgb_in[23:17]) || (|rgb_in[12:0])));
  end

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      state          <= IDLE;
      x_cnt          <= '0;
      y_cnt          <= '0;
      first_width    <= '0;
      loc_err_width  <= 1'b0;
      loc_err_sync   <= 1'b0;
      loc_err_sb     <= 1'b0;
      burst_since_hs <= 1'b0;
      pix_valid      <= 1'b0;
      pix_x          <= '0;
      pix_y          <= '0;
      pix_rgb        <= '0;
      line_done      <= 1'b0;
      line_width     <= '0;
      slot           <= '0;
      line_224       <= 1'b0;
      frame_done     <= 1'b0;
      frame_width    <= '0;
      frame_height   <= '0;
      err_width      <= 1'b0;
      err_sync       <= 1'b0;
      err_sideband   <= 1'b0;
    end else begin
      state      <= state_next;
      pix_valid  <= pix_take;
      line_done  <= line_end;
      frame_done <= 1'b0;
      if (pix_take) begin
        pix_x   <= burst_start ? 10'd0 : x_cnt;
        pix_y   <= y_cnt;
        pix_rgb <= rgb_in;
        x_cnt   <= x_next;
      end
      if (line_end) begin
        line_width <= x_cnt;
        slot       <= rgb_in[16:14];
        line_224   <= rgb_in[13];
      end
      if (vsync_in) begin
        if (frame_close && y_after != 10'd0) begin
          frame_done   <= 1'b1;
          frame_width  <= fw_after;
          frame_height <= y_after;
          err_width    <= ew_after;
          err_sync     <= es_after;
          err_sideband <= esb_after;
        end
        x_cnt          <= '0;
        y_cnt          <= '0;
        first_width    <= '0;
        loc_err_width  <= 1'b0;
        loc_err_sb     <= 1'b0;
        // a pixel dropped under vsync is charged to the new frame
        loc_err_sync   <= de_in;
        burst_since_hs <= 1'b0;
      end else begin
        y_cnt         <= y_after;
        first_width   <= fw_after;
        loc_err_width <= ew_after;
        loc_err_sync  <= es_after;
        loc_err_sb    <= esb_after;
        if (burst_start) burst_since_hs <= 1'b1;
        else if (hsync_in) burst_since_hs <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_video_stream_decoder.sv
// Self-checking bench for video_stream_decoder. Lines are described as
// (width, sideband) and the expected frame geometry and error flags are derived
// from the list of completed lines of each frame.
module tb_video_stream_decoder;

  logic        clk_vid = 1'b0;
  logic        reset;
  logic        vsync_in, hsync_in, de_in;
  logic [23:0] rgb_in;
  logic        pix_valid;
  logic [9:0]  pix_x, pix_y;
  logic [23:0] pix_rgb;
  logic        line_done;
  logic [9:0]  line_width;
  logic [2:0]  slot;
  logic        line_224;
  logic        frame_done;
  logic [9:0]  frame_width, frame_height;
  logic        err_width, err_sync, err_sideband;

  video_stream_decoder dut (
    .clk_vid      (clk_vid),
    .reset        (reset),
    .vsync_in     (vsync_in),
    .hsync_in     (hsync_in),
    .de_in        (de_in),
    .rgb_in       (rgb_in),
    .pix_valid    (pix_valid),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_rgb      (pix_rgb),
    .line_done    (line_done),
    .line_width   (line_width),
    .slot         (slot),
    .line_224     (line_224),
    .frame_done   (frame_done),
    .frame_width  (frame_width),
    .frame_height (frame_height),
    .err_width    (err_width),
    .err_sync     (err_sync),
    .err_sideband (err_sideband)
  );

  always #5 clk_vid = ~clk_vid;

  int          checks = 0;
  int          errors = 0;
  int          ln_w[$];
  logic [23:0] ln_sb[$];
  bit          cur_sync = 1'b0;
  int          last_h = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic h, input logic d, input logic [23:0] c);
    @(negedge clk_vid);
    vsync_in = v;
    hsync_in = h;
    de_in    = d;
    rgb_in   = c;
    @(posedge clk_vid);
    #1;
  endtask

  task automatic pixel(input int col);
    logic [23:0] r;
    r = 24'($urandom);
    cyc(1'b0, 1'b0, 1'b1, r);
    chk("pix_valid", pix_valid, 1);
    chk("pix_x", pix_x, col);
    chk("pix_y", pix_y, ln_w.size());
    chk("pix_rgb", pix_rgb, r);
  endtask

  task automatic check_frame();
    int fw, h;
    bit ew, esb;
    h   = ln_w.size();
    fw  = ln_w[0];
    ew  = 1'b0;
    esb = 1'b0;
    foreach (ln_w[i]) begin
      if (ln_w[i] != fw) ew = 1'b1;
      if ((ln_sb[i] & 24'hFE1FFF) != 24'h0) esb = 1'b1;
    end
    chk("frame_done", frame_done, 1);
    chk("frame_width", frame_width, fw);
    chk("frame_height", frame_height, h);
    chk("err_width", err_width, ew);
    chk("err_sideband", err_sideband, esb);
    chk("err_sync", err_sync, cur_sync);
    last_h = h;
    ln_w.delete();
    ln_sb.delete();
    cur_sync = 1'b0;
  endtask

  task automatic start_frame();
    cyc(1'b1, 1'b0, 1'b0, 24'($urandom));
    if (ln_w.size() != 0) begin
      check_frame();
    end else begin
      chk("empty_no_done", frame_done, 0);
      chk("empty_hold_height", frame_height, last_h);
    end
    cyc(1'b0, 1'b0, 1'b0, 24'h0);
    chk("frame_done_pulse", frame_done, 0);
  endtask

  task automatic send_line(input int w, input logic [23:0] sb, input bit vs_on_sb);
    cyc(1'b0, 1'b1, 1'b0, 24'h0);
    for (int i = 0; i < w; i++) pixel(i);
    cyc(vs_on_sb, 1'b0, 1'b0, sb);
    ln_w.push_back(w);
    ln_sb.push_back(sb);
    chk("line_done", line_done, 1);
    chk("line_width", line_width, w);
    chk("slot", slot, sb[16:14]);
    chk("line_224", line_224, sb[13]);
    chk("pix_valid_after", pix_valid, 0);
    if (vs_on_sb) check_frame();
  endtask

  task automatic abort_line(input int n);
    cyc(1'b0, 1'b1, 1'b0, 24'h0);
    for (int i = 0; i < n; i++) pixel(i);
    cyc(1'b1, 1'b0, 1'b1, 24'($urandom));
    chk("abort_no_line_done", line_done, 0);
    chk("abort_pix_dropped", pix_valid, 0);
    check_frame();
    cur_sync = 1'b1;
  endtask

  initial begin
    reset    = 1'b1;
    vsync_in = 1'b0;
    hsync_in = 1'b0;
    de_in    = 1'b0;
    rgb_in   = 24'h0;
    repeat (2) @(posedge clk_vid);
    #1;
    chk("rst_pix", {pix_valid, pix_x, pix_y, pix_rgb}, 0);
    chk("rst_line", {line_done, line_width, slot, line_224}, 0);
    chk("rst_frame", {frame_done, frame_width, frame_height, err_width, err_sync, err_sideband}, 0);
    reset = 1'b0;

    // IDLE ignores de until the first vsync
    cyc(1'b0, 1'b1, 1'b1, 24'h123456);
    chk("idle_ignore", pix_valid, 0);
    start_frame();

    for (int l = 0; l < 224; l++) send_line(256, 24'h000000, 1'b0);
    start_frame();

    for (int l = 0; l < 4; l++) send_line(360, 24'h006000, 1'b0);
    start_frame();

    for (int l = 0; l < 240; l++) send_line((l == 10) ? 32 : 16, 24'h000000, 1'b0);
    start_frame();

    for (int l = 0; l < 3; l++) send_line(20, 24'h00C000, 1'b0);
    start_frame();

    send_line(10, 24'h000000, 1'b0);
    send_line(10, 24'h800000, 1'b0);
    send_line(10, 24'h000000, 1'b0);
    start_frame();

    for (int l = 0; l < 5; l++) send_line(120, 24'h000000, 1'b0);
    abort_line(100);
    send_line(8, 24'h002000, 1'b0);
    send_line(8, 24'h002000, 1'b0);
    start_frame();
    start_frame();

    for (int f = 0; f < 4; f++) begin
      int n, base, w;
      bit vs_end;
      logic [23:0] sb;
      n      = $urandom_range(1, 6);
      base   = $urandom_range(1, 40);
      vs_end = 1'($urandom);
      for (int l = 0; l < n; l++) begin
        w = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : base;
        if ($urandom_range(0, 3) == 0) sb = 24'($urandom);
        else sb = {7'b0, 3'($urandom), 1'($urandom), 13'b0};
        send_line(w, sb, vs_end && (l == n - 1));
      end
      if (!vs_end) start_frame();
    end

    for (int l = 0; l < 3; l++) send_line(60, 24'h00A000, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 24'h0);
    for (int i = 0; i < 50; i++) pixel(i);
    @(negedge clk_vid);
    reset  = 1'b1;
    de_in  = 1'b1;
    rgb_in = 24'hABCDEF;
    @(posedge clk_vid);
    #1;
    chk("midreset_pix", {pix_valid, pix_x, pix_y, pix_rgb}, 0);
    chk("midreset_line", {line_done, line_width, slot, line_224}, 0);
    chk("midreset_frame", {frame_done, frame_width, frame_height, err_width, err_sync, err_sideband}, 0);
    reset = 1'b0;
    ln_w.delete();
    ln_sb.delete();
    cur_sync = 1'b0;
    last_h   = 0;
    cyc(1'b0, 1'b1, 1'b0, 24'h0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 24'h111111);
      chk("post_reset_ignore", pix_valid, 0);
    end
    cyc(1'b0, 1'b0, 1'b0, 24'h006000);
    chk("post_reset_no_line", line_done, 0);
    chk("post_reset_width", line_width, 0);
    start_frame();
    send_line(12, 24'h004000, 1'b0);
    start_frame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
